// File: rtl/lfsr_pkg.sv
// Shared constants and tap table for the lfsr_prng pseudo-random source.
// The tap mask has bit (t-1) set for every 1-indexed tap t of a maximal-length
// Fibonacci LFSR of the requested width.
package lfsr_pkg;

    localparam int LFSR_MIN_BITS = 2;
    localparam int LFSR_MAX_BITS = 16;

    function automatic logic [15:0] lfsr_taps(int n);
        logic [15:0] mask;
        case (n)
            2:       mask = 16'h0003;
            3:       mask = 16'h0006;
            4:       mask = 16'h000C;
            5:       mask = 16'h0014;
            6:       mask = 16'h0030;
            7:       mask = 16'h0060;
            8:       mask = 16'h00B8;
            9:       mask = 16'h0110;
            10:      mask = 16'h0240;
            11:      mask = 16'h0500;
            12:      mask = 16'h0829;
            13:      mask = 16'h100D;
            14:      mask = 16'h2015;
            15:      mask = 16'h6000;
            16:      mask = 16'hD008;
            default: mask = 16'h0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/lfsr_next.sv
// Purely combinational next-state function of the Fibonacci LFSR: shift left
// by one and insert the XOR of the tapped bits at bit 0.
// With LFSR_FULL_PERIOD_EN defined the feedback also flips whenever every bit
// below the MSB is zero, which splices the all-zero state into the cycle.
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int NUM_BITS = 3
) (
    input  logic [NUM_BITS-1:0] state_i,
    input  logic [NUM_BITS-1:0] taps_i,
    output logic [NUM_BITS-1:0] next_o
);

    logic fb;

    // Feedback bit from the tapped state bits, then shift it in at the bottom.
    always_comb begin
        fb = ^(state_i & taps_i);
`ifdef LFSR_FULL_PERIOD_EN
        fb = fb ^ (state_i[NUM_BITS-2:0] == '0);
`endif
        next_o = {state_i[NUM_BITS-2:0], fb};
    end

endmodule

// File: rtl/lfsr_prng.sv
// Maximal-length LFSR pseudo-random source for cache victim selection.
// Holds the single state register; reset loads SEED, enable advances one step.
// Optional macro LFSR_FULL_PERIOD_EN: de Bruijn extension, period 2^NUM_BITS
// including the all-zero state (SEED of zero becomes legal).
module lfsr_prng
    import lfsr_pkg::*;
#(
    parameter int                  NUM_BITS = 3,
    parameter logic [NUM_BITS-1:0] SEED     = {{(NUM_BITS-1){1'b0}}, 1'b1}
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    output logic [NUM_BITS-1:0] lfsr
);

    localparam logic [15:0]         TAPS_ALL = lfsr_taps(NUM_BITS);
    localparam logic [NUM_BITS-1:0] TAPS     = TAPS_ALL[NUM_BITS-1:0];

    // Reject widths outside the tap table and a zero seed that would lock up.
    generate
        if (NUM_BITS < LFSR_MIN_BITS || NUM_BITS > LFSR_MAX_BITS) begin : g_bad_width
            $error("lfsr_prng: NUM_BITS=%0d outside legal range 2..16", NUM_BITS);
        end
`ifndef LFSR_FULL_PERIOD_EN
        if (SEED == '0) begin : g_bad_seed
            $error("lfsr_prng: SEED must be nonzero without LFSR_FULL_PERIOD_EN");
        end
`endif
    endgenerate

    logic [NUM_BITS-1:0] state_q;
    logic [NUM_BITS-1:0] state_d;
    logic [NUM_BITS-1:0] step;

    lfsr_next #(
        .NUM_BITS(NUM_BITS)
    ) u_next (
        .state_i(state_q),
        .taps_i (TAPS),
        .next_o (step)
    );

    // Next state: reset wins over enable, otherwise advance or hold.
    always_comb begin
        state_d = state_q;
        if (reset) begin
            state_d = SEED;
        end else if (enable) begin
            state_d = step;
        end
    end

    // State register; output is taken straight from it.
    always_ff @(posedge clock) begin
        state_q <= state_d;
    end

    assign lfsr = state_q;

endmodule

// File: tb/tb_lfsr_prng.sv
// Self-checking bench for lfsr_prng: directed sequences, randomized
// enable/reset against a sequence-table model, and a width sweep 2..16
// that measures the cycle length of every width.
module tb_lfsr_prng;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [2:0] lfsr;

    logic sweepReset;
    logic sweepEnable;
    logic sweepCount;

    logic [16*32+31:64] periodFlat;
    logic [16:2]        doneFlat;
    logic [16:2]        zeroFlat;
    logic [16*16+15:32] outFlat;

    int total;
    int bad;

    int seqTable[$];
    int seq2Table[$];
    int idx;

    lfsr_prng #(
        .NUM_BITS(3),
        .SEED    (3'd1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .enable(enable),
        .lfsr  (lfsr)
    );

    // One instance per legal width, all free-running together during the sweep.
    for (genvar g = 2; g <= 16; g++) begin : gSweep
        logic [g-1:0] out;
        int           cnt;
        logic         done;
        logic         zero;

        lfsr_prng #(
            .NUM_BITS(g),
            .SEED    ({{(g-1){1'b0}}, 1'b1})
        ) u (
            .clock (clock),
            .reset (sweepReset),
            .enable(sweepEnable),
            .lfsr  (out)
        );

        // Count steps until the seed value comes back, noting any zero seen.
        always @(negedge clock) begin
            if (sweepReset) begin
                cnt  <= 0;
                done <= 1'b0;
                zero <= 1'b0;
            end else if (sweepCount && !done) begin
                cnt <= cnt + 1;
                if (out == '0) zero <= 1'b1;
                if (out == {{(g-1){1'b0}}, 1'b1}) done <= 1'b1;
            end
        end

        assign periodFlat[32*g +: 32] = cnt;
        assign doneFlat[g]            = done;
        assign zeroFlat[g]            = zero;
        assign outFlat[16*g +: 16]    = 16'(out);
    end

    // Free-running clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle, advance the model, then compare after the edge.
    task automatic applyStimulus(input bit rst, input bit en, input string tag);
        reset  = rst;
        enable = en;
        @(posedge clock);
        #1;
        if (rst) idx = 0;
        else if (en) idx = (idx + 1) % seqTable.size();
        checkOutput(tag, int'(lfsr), seqTable[idx]);
    endtask

    initial begin
        int expPeriod;
        int expZero;
        bit rst;
        bit en;

        total = 0;
        bad   = 0;
        idx   = 0;
`ifdef LFSR_FULL_PERIOD_EN
        seqTable  = '{1, 2, 5, 3, 7, 6, 4, 0};
        seq2Table = '{1, 3, 2, 0};
`else
        seqTable  = '{1, 2, 5, 3, 7, 6, 4};
        seq2Table = '{1, 3, 2};
`endif
        reset       = 1'b1;
        enable      = 1'b1;
        sweepReset  = 1'b1;
        sweepEnable = 1'b0;
        sweepCount  = 1'b0;

        // Reset for two cycles with enable high: reset must win.
        applyStimulus(1'b1, 1'b1, "reset0");
        applyStimulus(1'b1, 1'b1, "reset1");

        // Full cycle back to the seed.
        for (int i = 0; i < seqTable.size(); i++) applyStimulus(1'b0, 1'b1, "seq");

        // Walk to state 5, hold it, then resume.
        applyStimulus(1'b0, 1'b1, "toTwo");
        applyStimulus(1'b0, 1'b1, "toFive");
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, "hold");
        applyStimulus(1'b0, 1'b1, "resume");
        applyStimulus(1'b0, 1'b1, "toSeven");

        // Reset mid-sequence with enable high, then restart.
        applyStimulus(1'b1, 1'b1, "midReset");
        applyStimulus(1'b0, 1'b1, "restart1");
        applyStimulus(1'b0, 1'b1, "restart2");

        // Randomized enable with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 19) == 0);
            en  = 1'($urandom_range(0, 1));
            applyStimulus(rst, en, "random");
        end
        reset  = 1'b0;
        enable = 1'b0;

        // Width sweep: release all instances together and measure periods.
        repeat (2) @(posedge clock);
        @(negedge clock);
        sweepReset  = 1'b0;
        sweepEnable = 1'b1;
        @(posedge clock);
        #1;
        sweepCount = 1'b1;
        checkOutput("n2step1", int'(outFlat[32 +: 16]), seq2Table[1 % seq2Table.size()]);
        @(posedge clock);
        #1;
        checkOutput("n2step2", int'(outFlat[32 +: 16]), seq2Table[2 % seq2Table.size()]);
        @(posedge clock);
        #1;
        checkOutput("n2step3", int'(outFlat[32 +: 16]), seq2Table[3 % seq2Table.size()]);

        for (int c = 0; c < 70000 && !(&doneFlat); c++) @(posedge clock);
        @(posedge clock);
        #1;

        for (int g = 2; g <= 16; g++) begin
`ifdef LFSR_FULL_PERIOD_EN
            expPeriod = 1 << g;
            expZero   = 1;
`else
            expPeriod = (1 << g) - 1;
            expZero   = 0;
`endif
            checkOutput($sformatf("done%0d", g), int'(doneFlat[g]), 1);
            checkOutput($sformatf("period%0d", g), int'(periodFlat[32*g +: 32]), expPeriod);
            checkOutput($sformatf("zero%0d", g), int'(zeroFlat[g]), expZero);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
